// File: rtl/quad_duty_gen.sv
// Quadrature encoder front end: filters A/B, keeps a saturating signed position,
// and slews a 9-bit duty command that only moves on PWM frame boundaries.
module quad_duty_gen #(
  parameter int FILT_LEN = 4,
  parameter int POS_W    = 16,
  parameter int STEP_MAX = 8,
  parameter int DUTY_MID = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    zero,
  input  logic                    servo_en,
  output logic [8:0]              duty,
  output logic                    duty_upd,
  output logic signed [POS_W-1:0] position,
  output logic                    dir,
  output logic                    err
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TW = (POS_W + 2 > 11) ? POS_W + 2 : 11;
  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [8:0] STEP = 9'(STEP_MAX);

  logic [1:0] enc_raw;
  logic [1:0] filt;
  logic [1:0] prev_reg;
  logic       up_next, dn_next, bad_next;
  logic       up_reg, dn_reg, bad_reg;
  logic       sen_reg;
  logic       boundary;
  logic [TW-1:0] tgt_wide;
  logic [8:0] tgt;
  logic [8:0] diff;
  logic [8:0] duty_next;

  assign enc_raw = {enc_a, enc_b};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic          s1_reg, s2_reg, f_reg;
      logic [FW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          f_reg   <= 1'b0;
          cnt_reg <= '0;
        end else begin
          s1_reg <= enc_raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == f_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == FW'(FILT_LEN - 1)) begin
            f_reg   <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign filt[gi] = f_reg;
    end
  endgenerate

  // Gray-code transitions {prev, now}; a two-bit jump means a missed state.
  always_comb begin
    up_next  = 1'b0;
    dn_next  = 1'b0;
    bad_next = 1'b0;
    case ({prev_reg, filt})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: up_next  = 1'b1;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: dn_next  = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: bad_next = 1'b1;
      default: ;
    endcase
  end

  // Decoded events are registered once more so a pin change reaches position
  // FILT_LEN+3 edges after it is first sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_reg <= 2'b00;
      up_reg   <= 1'b0;
      dn_reg   <= 1'b0;
      bad_reg  <= 1'b0;
    end else begin
      prev_reg <= filt;
      up_reg   <= up_next;
      dn_reg   <= dn_next;
      bad_reg  <= bad_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      position <= '0;
      dir      <= 1'b0;
      err      <= 1'b0;
    end else if (zero) begin
      position <= '0;
      err      <= 1'b0;
    end else if (bad_reg) begin
      err <= 1'b1;
    end else if (up_reg) begin
      dir <= 1'b1;
      if (position != POS_MAX)
        position <= position + POS_W'(1);
    end else if (dn_reg) begin
      dir <= 1'b0;
      if (position != POS_MIN)
        position <= position - POS_W'(1);
    end
  end

  // Sign-extend position, offset to mid-scale, then clamp to 0..511.
  always_comb begin
    tgt_wide = {{(TW-POS_W){position[POS_W-1]}}, position} + TW'(DUTY_MID);
    if (tgt_wide[TW-1])
      tgt = 9'd0;
    else if (|tgt_wide[TW-2:9])
      tgt = 9'd511;
    else
      tgt = tgt_wide[8:0];
  end

  always_comb begin
    diff      = 9'd0;
    duty_next = duty;
    if (tgt > duty) begin
      diff      = tgt - duty;
      duty_next = duty + ((diff > STEP) ? STEP : diff);
    end else if (tgt < duty) begin
      diff      = duty - tgt;
      duty_next = duty - ((diff > STEP) ? STEP : diff);
    end
  end

  assign boundary = servo_en ^ sen_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sen_reg  <= 1'b0;
      duty     <= 9'(DUTY_MID);
      duty_upd <= 1'b0;
    end else begin
      sen_reg  <= servo_en;
      duty_upd <= boundary;
      if (boundary)
        duty <= duty_next;
    end
  end

endmodule

// File: tb/tb_quad_duty_gen.sv
// Randomized bench for quad_duty_gen: two instances (POS_W 16 and 8) share the
// stimulus and are compared against a transaction-level position/duty model.
module tb_quad_duty_gen;

  localparam int F = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enc_a = 1'b0, enc_b = 1'b0, zero = 1'b0, servo_en = 1'b0;

  logic [8:0]         duty16, duty8;
  logic               upd16, upd8, dir16, dir8, err16, err8;
  logic signed [15:0] pos16;
  logic signed [7:0]  pos8;

  always #5 clk = ~clk;

  quad_duty_gen #(.FILT_LEN(F), .POS_W(16), .STEP_MAX(8), .DUTY_MID(256)) u_dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .zero(zero),
    .servo_en(servo_en), .duty(duty16), .duty_upd(upd16), .position(pos16),
    .dir(dir16), .err(err16)
  );

  quad_duty_gen #(.FILT_LEN(F), .POS_W(8), .STEP_MAX(8), .DUTY_MID(256)) u_sat (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .zero(zero),
    .servo_en(servo_en), .duty(duty8), .duty_upd(upd8), .position(pos8),
    .dir(dir8), .err(err8)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: encoder phase index 0..3 along 00,01,11,10.
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int m_idx, m_pos16, m_pos8, m_duty16, m_duty8, m_dir, m_err;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int step_pos(input int p, input int d, input int w);
    int lo, hi;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    return ((p + d) > hi || (p + d) < lo) ? p : p + d;
  endfunction

  function automatic int tgt_of(input int p);
    return clamp(p + 256, 0, 511);
  endfunction

  function automatic int slew(input int d, input int t);
    if (t > d) return d + ((t - d > 8) ? 8 : t - d);
    if (t < d) return d - ((d - t > 8) ? 8 : d - t);
    return d;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_pos16 = 0; m_pos8 = 0; m_duty16 = 256; m_duty8 = 256;
    m_dir = 0; m_err = 0;
  endtask

  task automatic model_move(input int new_idx);
    case ((new_idx - m_idx + 4) % 4)
      1: begin m_dir = 1; m_pos16 = step_pos(m_pos16, 1, 16); m_pos8 = step_pos(m_pos8, 1, 8); end
      3: begin m_dir = 0; m_pos16 = step_pos(m_pos16, -1, 16); m_pos8 = step_pos(m_pos8, -1, 8); end
      2: m_err = 1;
      default: ;
    endcase
    m_idx = new_idx;
  endtask

  task automatic model_boundary();
    m_duty16 = slew(m_duty16, tgt_of(m_pos16));
    m_duty8  = slew(m_duty8, tgt_of(m_pos8));
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "_pos16"}, int'(pos16), m_pos16);
    check_val({tag, "_pos8"}, int'(pos8), m_pos8);
    check_val({tag, "_dir"}, int'(dir16), m_dir);
    check_val({tag, "_dir8"}, int'(dir8), m_dir);
    check_val({tag, "_err"}, int'(err16), m_err);
    check_val({tag, "_err8"}, int'(err8), m_err);
    check_val({tag, "_duty16"}, int'(duty16), m_duty16);
    check_val({tag, "_duty8"}, int'(duty8), m_duty8);
    check_val({tag, "_upd"}, int'(upd16), 0);
  endtask

  task automatic drive_move(input int new_idx, input string tag);
    @(negedge clk);
    {enc_a, enc_b} = gray[new_idx];
    repeat (F + 4) @(posedge clk);
    @(negedge clk);
    model_move(new_idx);
    $display("move %s ab=%b pos16=%0d pos8=%0d", tag, gray[new_idx], pos16, pos8);
    check_all(tag);
  endtask

  task automatic boundary(input string tag);
    @(negedge clk);
    servo_en = ~servo_en;
    @(negedge clk);
    model_boundary();
    $display("boundary %s duty16=%0d duty8=%0d", tag, duty16, duty8);
    check_val({tag, "_upd16"}, int'(upd16), 1);
    check_val({tag, "_upd8"}, int'(upd8), 1);
    check_val({tag, "_duty16"}, int'(duty16), m_duty16);
    check_val({tag, "_duty8"}, int'(duty8), m_duty8);
    @(negedge clk);
    check_val({tag, "_upd_off"}, int'(upd16), 0);
  endtask

  task automatic do_zero(input string tag);
    @(negedge clk);
    zero = 1'b1;
    @(negedge clk);
    zero = 1'b0;
    m_pos16 = 0; m_pos8 = 0; m_err = 0;
    $display("zero %s", tag);
    check_all(tag);
  endtask

  task automatic glitch(input int ch, input int len);
    @(negedge clk);
    if (ch == 0) enc_a = ~enc_a; else enc_b = ~enc_b;
    repeat (len) @(negedge clk);
    {enc_a, enc_b} = gray[m_idx];
    repeat (F + 4) @(negedge clk);
    $display("glitch ch=%0d len=%0d pos16=%0d", ch, len, pos16);
    check_all("glitch");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, n;
    model_reset();

    // Reset held with random input activity.
    repeat (20) begin
      @(negedge clk);
      enc_a = 1'($urandom); enc_b = 1'($urandom); servo_en = 1'($urandom);
    end
    $display("reset held pos16=%0d duty16=%0d", pos16, duty16);
    check_all("rst");
    @(negedge clk);
    {enc_a, enc_b} = 2'b00;
    servo_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all("rel");
    boundary("first");

    // Latency of the first forward step.
    @(negedge clk);
    {enc_a, enc_b} = gray[1];
    repeat (F + 3) @(posedge clk);
    #1 check_val("lat_early", int'(pos16), 0);
    @(posedge clk);
    #1 check_val("lat_step", int'(pos16), 1);
    @(negedge clk);
    model_move(1);
    $display("move lat pos16=%0d", pos16);
    for (int i = 1; i < 12; i++) drive_move((m_idx + 1) % 4, "fwd");
    check_val("fwd12", int'(pos16), 12);
    for (int i = 0; i < 5; i++) drive_move((m_idx + 3) % 4, "rev");
    check_val("rev7", int'(pos16), 7);

    glitch(0, 3);
    drive_move((m_idx + 2) % 4, "illegal");
    check_val("illegal_err", int'(err16), 1);
    do_zero("zero");

    // Slew up towards tgt=356.
    for (int i = 0; i < 100; i++) drive_move((m_idx + 1) % 4, "up");
    for (int i = 0; i < 14; i++) boundary("slew_up");
    check_val("slew_top", int'(duty16), 356);
    for (int i = 0; i < 30; i++) drive_move((m_idx + 1) % 4, "up");
    check_val("sat_hi", int'(pos8), 127);
    for (int i = 0; i < 430; i++) drive_move((m_idx + 3) % 4, "down");
    check_val("neg300", int'(pos16), -300);
    check_val("sat_lo", int'(pos8), -128);
    n = 0;
    while (m_duty16 != 0 && n < 60) begin
      boundary("slew_dn");
      n++;
    end
    boundary("slew_floor");
    check_val("duty_floor", int'(duty16), 0);
    do_zero("zero2");

    // Random mix of steps, illegal jumps, glitches, clears and boundaries.
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      drive_move((m_idx + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4, "rnd");
      else if (r < 62) drive_move((m_idx + 2) % 4, "rnd_bad");
      else if (r < 72) glitch($urandom_range(0, 1), $urandom_range(1, F - 1));
      else if (r < 78) do_zero("rnd_zero");
      else             boundary("rnd_bnd");
    end

    // zero coincident with a forward step (dir already 1).
    drive_move((m_idx + 1) % 4, "pre");
    @(negedge clk);
    {enc_a, enc_b} = gray[(m_idx + 1) % 4];
    repeat (F + 3) @(posedge clk);
    @(negedge clk);
    zero = 1'b1;
    @(negedge clk);
    zero = 1'b0;
    m_idx = (m_idx + 1) % 4; m_pos16 = 0; m_pos8 = 0; m_err = 0;
    $display("zero+step pos16=%0d", pos16);
    check_all("zstep");

    // Step coincident with a boundary: duty settles, then must not see the step.
    for (int i = 0; i < 20; i++) drive_move((m_idx + 1) % 4, "pre2");
    n = 0;
    while ((m_duty16 != tgt_of(m_pos16) || m_duty8 != tgt_of(m_pos8)) && n < 80) begin
      boundary("settle");
      n++;
    end
    @(negedge clk);
    {enc_a, enc_b} = gray[(m_idx + 1) % 4];
    repeat (F + 3) @(posedge clk);
    @(negedge clk);
    servo_en = ~servo_en;
    @(negedge clk);
    model_boundary();
    model_move((m_idx + 1) % 4);
    $display("step+boundary duty16=%0d pos16=%0d", duty16, pos16);
    check_val("sb_upd", int'(upd16), 1);
    check_val("sb_duty", int'(duty16), m_duty16);
    @(negedge clk);
    check_all("sb");

    // Asynchronous reset in the middle of a slew.
    for (int i = 0; i < 10; i++) drive_move((m_idx + 3) % 4, "pre3");
    boundary("mid");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    $display("async reset duty16=%0d pos16=%0d", duty16, pos16);
    check_val("ar_duty16", int'(duty16), 256);
    check_val("ar_duty8", int'(duty8), 256);
    check_val("ar_pos", int'(pos16), 0);
    check_val("ar_upd", int'(upd16), 0);
    @(negedge clk);
    {enc_a, enc_b} = 2'b00;
    servo_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (F + 5) @(negedge clk);
    check_all("post_rst");
    boundary("post_rst_bnd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
